// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared register selects, control layout and hex font for seg7_scan
package seg7_pkg;

  localparam logic [1:0] SEL_VALUE = 2'd0;
  localparam logic [1:0] SEL_DP    = 2'd1;
  localparam logic [1:0] SEL_CTRL  = 2'd2;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_BLANK_LZ = 1;

  typedef struct packed {
    logic blank_lz;
    logic enable;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{blank_lz: 1'b0, enable: 1'b1};

  // Active-low gfedcba; element [0] is the glyph for hex 0.
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - register write port from the system16 I/O decode
interface seg7_scan_if;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [15:0] wr_data;

  modport master (output wr_en, output wr_sel, output wr_data);
  modport slave  (input  wr_en, input  wr_sel, input  wr_data);
endinterface

// File: rtl/seg7_font.sv
// rtl/seg7_font.sv - hex nibble to active-low 7-segment pattern
module seg7_font
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = FONT[nibble];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - double-buffered 4-digit multiplexed 7-segment driver
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int GUARD = 500
) (
  input  logic        clk,
  input  logic        reset_n,
  seg7_scan_if.slave  wr,
  output logic [6:0]  segments,
  output logic        decimal_point,
  output logic [3:0]  anode,
  output logic        frame_tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] prescaler;
  logic [1:0]    digit_idx;
  logic [15:0]   shadow;
  logic [15:0]   display;
  logic [3:0]    dp_mask;
  ctrl_t         ctrl;

  logic          wr_value;
  logic          wr_dp;
  logic          wr_ctrl;
  logic          slot_end;
  logic          frame_end;
  logic          in_guard;
  ctrl_t         ctrl_eff;
  logic [3:0]    mask_eff;
  logic [15:0]   shifted;
  logic          blank;
  logic [6:0]    font_seg;

  logic [3:0]    anode_d;
  logic [6:0]    segments_d;
  logic          dp_d;

  assign wr_value  = wr.wr_en && (wr.wr_sel == SEL_VALUE);
  assign wr_dp     = wr.wr_en && (wr.wr_sel == SEL_DP);
  assign wr_ctrl   = wr.wr_en && (wr.wr_sel == SEL_CTRL);

  assign slot_end  = (prescaler == PW'(DIV - 1));
  assign frame_end = slot_end && (digit_idx == 2'd3);
  assign in_guard  = (prescaler < PW'(GUARD));

  // Mask and control writes bypass their registers so they shape this cycle's drive.
  assign ctrl_eff  = wr_ctrl ? ctrl_t'(wr.wr_data[1:0]) : ctrl;
  assign mask_eff  = wr_dp ? wr.wr_data[3:0] : dp_mask;

  // Shifting the current digit down to bit 0 leaves only it and the digits to its left,
  // so a zero result means every more-significant nibble is zero too.
  assign shifted   = display >> {digit_idx, 2'b00};
  assign blank     = ctrl_eff.blank_lz && (digit_idx != 2'd0) && (shifted == 16'h0000);

  seg7_font u_font (
    .nibble   (shifted[3:0]),
    .segments (font_seg)
  );

  always_comb begin
    anode_d    = 4'hF;
    segments_d = 7'h7F;
    dp_d       = 1'b1;
    if (!in_guard) begin
      if (ctrl_eff.enable) begin
        anode_d = ~(4'b0001 << digit_idx);
      end
      segments_d = blank ? 7'h7F : font_seg;
      dp_d       = ~mask_eff[digit_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      digit_idx <= 2'd0;
      shadow    <= 16'h0000;
      display   <= 16'h0000;
      dp_mask   <= 4'h0;
      ctrl      <= CTRL_RESET;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + 1'b1;
      if (slot_end) begin
        digit_idx <= digit_idx + 2'd1;
      end
      if (wr_value) begin
        shadow <= wr.wr_data;
      end
      // A value write landing on the frame boundary goes straight to the display.
      if (frame_end) begin
        display <= wr_value ? wr.wr_data : shadow;
      end
      if (wr_dp) begin
        dp_mask <= wr.wr_data[3:0];
      end
      if (wr_ctrl) begin
        ctrl <= ctrl_t'(wr.wr_data[1:0]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      anode         <= 4'hF;
      segments      <= 7'h7F;
      decimal_point <= 1'b1;
      frame_tick    <= 1'b0;
    end else begin
      anode         <= anode_d;
      segments      <= segments_d;
      decimal_point <= dp_d;
      frame_tick    <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized and directed bench for seg7_scan against a cycle-count model
module tb_seg7_scan;

  localparam int DIV   = 8;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] segments;
  logic       decimal_point;
  logic [3:0] anode;
  logic       frame_tick;

  seg7_scan_if wif ();

  seg7_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr            (wif),
    .segments      (segments),
    .decimal_point (decimal_point),
    .anode         (anode),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: cyc counts clock edges since reset release, so slot and digit follow from it.
  int          cyc;
  logic [15:0] m_shadow;
  logic [15:0] m_disp;
  logic [3:0]  m_mask;
  logic        m_en;
  logic        m_blz;
  bit          post_reset;

  logic [3:0]  exp_anode;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic        exp_tick;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    m_shadow  = 16'h0000;
    m_disp    = 16'h0000;
    m_mask    = 4'h0;
    m_en      = 1'b1;
    m_blz     = 1'b0;
    exp_anode = 4'hF;
    exp_seg   = 7'h7F;
    exp_dp    = 1'b1;
    exp_tick  = 1'b0;
  endtask

  task automatic compare_outputs();
    check("anode", {12'h0, anode}, {12'h0, exp_anode});
    check("segments", {9'h0, segments}, {9'h0, exp_seg});
    check("decimal_point", {15'h0, decimal_point}, {15'h0, exp_dp});
    check("frame_tick", {15'h0, frame_tick}, {15'h0, exp_tick});
  endtask

  task automatic lit(input logic [3:0] a, input logic [6:0] s, input logic d);
    check("lit_anode", {12'h0, anode}, {12'h0, a});
    check("lit_segments", {9'h0, segments}, {9'h0, s});
    check("lit_dp", {15'h0, decimal_point}, {15'h0, d});
  endtask

  task automatic literal_checks();
    if (post_reset) begin
      if (cyc == 2) lit(4'hF, 7'h7F, 1'b1);
      if (cyc == 3) lit(4'hE, 7'h40, 1'b1);
    end else begin
      case (cyc)
        2:   lit(4'hF, 7'h7F, 1'b1);
        3:   lit(4'hE, 7'h40, 1'b1);
        35:  lit(4'hE, 7'h19, 1'b1);
        43:  lit(4'hD, 7'h30, 1'b1);
        51:  lit(4'hB, 7'h24, 1'b1);
        59:  lit(4'h7, 7'h79, 1'b1);
        64:  check("lit_tick_hi", {15'h0, frame_tick}, 16'h1);
        65:  check("lit_tick_lo", {15'h0, frame_tick}, 16'h0);
        67:  lit(4'hE, 7'h21, 1'b1);
        91:  lit(4'h7, 7'h08, 1'b1);
        131: lit(4'hE, 7'h40, 1'b0);
        139: lit(4'hD, 7'h12, 1'b1);
        147: lit(4'hB, 7'h7F, 1'b0);
        155: lit(4'h7, 7'h7F, 1'b1);
        195: lit(4'hE, 7'h40, 1'b0);
        203: lit(4'hD, 7'h7F, 1'b1);
        229: check("lit_pre_disable", {12'h0, anode}, 16'h000E);
        230: check("lit_disabled", {12'h0, anode}, 16'h000F);
        240: check("lit_still_off", {12'h0, anode}, 16'h000F);
        251: lit(4'h7, 7'h40, 1'b1);
        default: ;
      endcase
    end
  endtask

  // Called at a negedge: drive one cycle of input, predict the next registered outputs,
  // then advance to the next negedge and compare.
  task automatic step(input bit we, input logic [1:0] sel, input logic [15:0] data);
    int          p;
    int          i;
    logic [15:0] sh;
    logic [3:0]  onehot;
    wif.wr_en   = we;
    wif.wr_sel  = sel;
    wif.wr_data = data;
    p = cyc % DIV;
    i = (cyc / DIV) % 4;
    if (we && sel == 2'd1) m_mask = data[3:0];
    if (we && sel == 2'd2) begin
      m_en  = data[0];
      m_blz = data[1];
    end
    if (p < GUARD) begin
      exp_anode = 4'hF;
      exp_seg   = 7'h7F;
      exp_dp    = 1'b1;
    end else begin
      onehot    = 4'h1 << i;
      exp_anode = m_en ? ~onehot : 4'hF;
      sh        = m_disp >> (4 * i);
      exp_seg   = (m_blz && i > 0 && sh == 16'h0) ? 7'h7F : font_tab[sh[3:0]];
      exp_dp    = ~m_mask[i];
    end
    exp_tick = (p == DIV - 1) && (i == 3);
    if (exp_tick) m_disp = (we && sel == 2'd0) ? data : m_shadow;
    if (we && sel == 2'd0) m_shadow = data;
    cyc++;
    @(negedge clk);
    compare_outputs();
    literal_checks();
  endtask

  initial begin
    bit          we;
    logic [1:0]  sel;
    logic [15:0] data;

    wif.wr_en   = 1'b0;
    wif.wr_sel  = 2'd0;
    wif.wr_data = 16'h0000;
    post_reset  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    lit(4'hF, 7'h7F, 1'b1);
    check("reset_tick", {15'h0, frame_tick}, 16'h0);
    reset_n = 1'b1;
    compare_outputs();

    for (int n = 0; n < 256; n++) begin
      we = 1'b1;
      case (n)
        0:   begin sel = 2'd0; data = 16'h1234; end
        63:  begin sel = 2'd0; data = 16'hABCD; end
        96:  begin sel = 2'd1; data = 16'h0005; end
        97:  begin sel = 2'd2; data = 16'h0003; end
        98:  begin sel = 2'd0; data = 16'h0050; end
        160: begin sel = 2'd0; data = 16'h0000; end
        229: begin sel = 2'd2; data = 16'h0000; end
        250: begin sel = 2'd2; data = 16'h0001; end
        default: begin we = 1'b0; sel = 2'd0; data = 16'h0000; end
      endcase
      step(we, sel, data);
    end

    for (int n = 0; n < 1500; n++) begin
      we   = ($urandom_range(0, 7) == 0);
      sel  = 2'($urandom_range(0, 3));
      data = 16'($urandom);
      if (cyc % (4 * DIV) == 4 * DIV - 1 && $urandom_range(0, 1) == 1) begin
        we  = 1'b1;
        sel = 2'd0;
      end
      if ($urandom_range(0, 15) == 0) data = 16'($urandom_range(0, 255));
      step(we, sel, data);
    end

    for (int n = 0; n < 4 * DIV; n++) begin
      if ((cyc / DIV) % 4 == 2 && cyc % DIV == 4) break;
      step(1'b0, 2'd0, 16'h0000);
    end
    check("reached_digit2", 16'((cyc / DIV) % 4), 16'd2);

    #2 reset_n = 1'b0;
    #1;
    lit(4'hF, 7'h7F, 1'b1);
    check("reset_async_tick", {15'h0, frame_tick}, 16'h0);
    wif.wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    post_reset = 1'b1;
    model_reset();
    compare_outputs();
    for (int n = 0; n < 5 * 4 * DIV; n++) begin
      step(1'b0, 2'd0, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
